aes_seq_ctrl: RTL and testbench

//  Parametrised sequencing FSM for the AES accelerator, between the AHB-Lite slave and the key-expansion/cipher core.
//  - Counts bus beats in for a key or a data block and handshakes the core.
//  - Counts result beats back out and flags protocol errors.
//  - Block and key beat counts are parameters, covering AES-128/192/256 keys and any bus width.

---
 rtl/aes_ctrl_pkg.sv | 25 ++
 rtl/aes_seq_ctrl_if.sv | 38 +++
 rtl/flex_counter.sv | 35 +++
 rtl/aes_seq_ctrl.sv | 164 ++++++++++++++++
 tb/tb_aes_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared types and helpers for the AES sequencing controller.
// State enum, job-type encodings and the beat-counter width helper.
package aes_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StKeyFetch,
        StKeyWait,
        StBlkFetch,
        StCoreStart,
        StCoreWait,
        StWrite,
        StError
    } aes_ctrl_state_t;

    localparam logic JOB_KEY  = 1'b1;
    localparam logic JOB_DATA = 1'b0;

    // Width needed to hold the larger of the two beat counts without wrapping.
    function automatic int unsigned beat_cnt_width(input int unsigned blk_beats,
                                                   input int unsigned key_beats);
        return $clog2(((blk_beats > key_beats) ? blk_beats : key_beats) + 1);
    endfunction

endpackage

// File: rtl/aes_seq_ctrl_if.sv
// Handshake bundle between the AHB slave / cipher core and the sequencer.
// master: the sequencer itself; slave: the surrounding AHB slave and core.
interface aes_seq_ctrl_if;

    logic start;
    logic data_type;
    logic enc_dec;
    logic data_valid;
    logic out_ready;
    logic key_done;
    logic core_done;
    logic clear_err;

    logic opt_mode;
    logic key_shift_en;
    logic blk_shift_en;
    logic load_key;
    logic core_start;
    logic out_valid;
    logic out_shift_en;
    logic done_chg_key;
    logic blk_done;
    logic busy;
    logic error;

    modport master (
        input  start, data_type, enc_dec, data_valid, out_ready, key_done, core_done, clear_err,
        output opt_mode, key_shift_en, blk_shift_en, load_key, core_start, out_valid,
               out_shift_en, done_chg_key, blk_done, busy, error
    );

    modport slave (
        output start, data_type, enc_dec, data_valid, out_ready, key_done, core_done, clear_err,
        input  opt_mode, key_shift_en, blk_shift_en, load_key, core_start, out_valid,
               out_shift_en, done_chg_key, blk_done, busy, error
    );

endinterface

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear (priority) and count enable.
module flex_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             count_enable,
    output logic [WIDTH-1:0] count_out
);

    logic [WIDTH-1:0] count_q, count_d;

    // Next count: clear wins over enable.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out = count_q;

endmodule

// File: rtl/aes_seq_ctrl.sv
// AES accelerator sequencer: counts key/block beats in, handshakes the core,
// counts result beats out and traps protocol errors.
// Optional macro AES_CTRL_TIMEOUT_EN adds a TIMEOUT_CYC watchdog on KEY_WAIT/CORE_WAIT.
module aes_seq_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int unsigned BEATS_PER_BLK = 4,
    parameter int unsigned KEY_BEATS     = 4,
    parameter int unsigned TIMEOUT_CYC   = 255
) (
    input logic           clk,
    input logic           n_rst,
    aes_seq_ctrl_if.master bus
);

    localparam int unsigned     CntW    = beat_cnt_width(BEATS_PER_BLK, KEY_BEATS);
    localparam logic [CntW-1:0] KeyLast = CntW'(KEY_BEATS - 1);
    localparam logic [CntW-1:0] BlkLast = CntW'(BEATS_PER_BLK - 1);

    aes_ctrl_state_t state_q, state_d;
    logic            opt_mode_q;
    logic            load_key_q;
    logic [CntW-1:0] beat_cnt;
    logic            beat_acc;
    logic            bad_start;
    logic            timeout;

    // A start outside IDLE/ERROR aborts the job and masks every strobe this cycle.
    assign bad_start = bus.start && (state_q != StIdle) && (state_q != StError);

    // Beat accepted in the current cycle (input beat or result beat).
    always_comb begin
        beat_acc = 1'b0;
        if (!bad_start) begin
            case (state_q)
                StKeyFetch, StBlkFetch: beat_acc = bus.data_valid;
                StWrite:                beat_acc = bus.out_ready;
                default:                beat_acc = 1'b0;
            endcase
        end
    end

`ifdef AES_CTRL_TIMEOUT_EN
    localparam int unsigned WaitW = $clog2(TIMEOUT_CYC + 1);
    logic [WaitW-1:0] wait_q, wait_d;
    logic             in_wait;

    assign in_wait = (state_q == StKeyWait) || (state_q == StCoreWait);
    assign timeout = in_wait && (wait_q == WaitW'(TIMEOUT_CYC - 1));

    // Wait counter restarts on every state change.
    always_comb begin
        wait_d = '0;
        if (in_wait && (state_d == state_q)) begin
            wait_d = wait_q + 1'b1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout            = 1'b0;
`endif

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        if (bad_start) begin
            state_d = StError;
        end else begin
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        case (bus.data_type)
                            JOB_KEY:  state_d = StKeyFetch;
                            JOB_DATA: state_d = StBlkFetch;
                            default:  state_d = StBlkFetch;
                        endcase
                    end
                end
                StKeyFetch:  if (beat_acc && (beat_cnt == KeyLast)) state_d = StKeyWait;
                StKeyWait: begin
                    if (bus.key_done)  state_d = StIdle;
                    else if (timeout)  state_d = StError;
                end
                StBlkFetch:  if (beat_acc && (beat_cnt == BlkLast)) state_d = StCoreStart;
                StCoreStart: state_d = StCoreWait;
                StCoreWait: begin
                    if (bus.core_done) state_d = StWrite;
                    else if (timeout)  state_d = StError;
                end
                StWrite:     if (beat_acc && (beat_cnt == BlkLast)) state_d = StIdle;
                StError:     if (bus.clear_err) state_d = StIdle;
                default:     state_d = StIdle;
            endcase
        end
    end

    // Beat counter: cleared on every state entry, advanced per accepted beat.
    flex_counter #(
        .WIDTH(CntW)
    ) u_beat_cnt (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (state_d != state_q),
        .count_enable (beat_acc),
        .count_out    (beat_cnt)
    );

    // State, latched job mode and the one-shot key-expansion request.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= StIdle;
            opt_mode_q <= 1'b0;
            load_key_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_key_q <= (state_q == StKeyFetch) && (state_d == StKeyWait);
            if ((state_q == StIdle) && bus.start) begin
                opt_mode_q <= bus.enc_dec;
            end
        end
    end

    // Output decode; strobes are masked in the cycle of an illegal start.
    always_comb begin
        bus.key_shift_en = 1'b0;
        bus.blk_shift_en = 1'b0;
        bus.load_key     = 1'b0;
        bus.core_start   = 1'b0;
        bus.out_shift_en = 1'b0;
        bus.done_chg_key = 1'b0;
        bus.blk_done     = 1'b0;
        bus.busy         = (state_q != StIdle);
        bus.error        = (state_q == StError);
        bus.out_valid    = (state_q == StWrite);
        bus.opt_mode     = opt_mode_q && (state_q != StError);
        if (!bad_start) begin
            case (state_q)
                StKeyFetch:  bus.key_shift_en = bus.data_valid;
                StKeyWait: begin
                    bus.load_key     = load_key_q;
                    bus.done_chg_key = bus.key_done;
                end
                StBlkFetch:  bus.blk_shift_en = bus.data_valid;
                StCoreStart: bus.core_start   = 1'b1;
                StWrite: begin
                    bus.out_shift_en = bus.out_ready;
                    bus.blk_done     = bus.out_ready && (beat_cnt == BlkLast);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Self-checking bench for aes_seq_ctrl (KEY_BEATS=8, BEATS_PER_BLK=4, TIMEOUT_CYC=16).
// Inputs change at negedge; outputs are compared 2 time units later.
module tb_aes_seq_ctrl;

    localparam int KB  = 8;
    localparam int BPB = 4;
    localparam int TO  = 16;

    // Input vector bits: {start, data_type, enc_dec, data_valid, out_ready, key_done, core_done,
    // clear_err}
    localparam logic [7:0] I_CLR = 8'h01, I_CD = 8'h02, I_KD = 8'h04, I_RDY = 8'h08;
    localparam logic [7:0] I_DV  = 8'h10, I_ED = 8'h20, I_DT = 8'h40, I_ST  = 8'h80;
    // Output vector bits: {opt_mode, key_shift_en, blk_shift_en, load_key, core_start, out_valid,
    // out_shift_en, done_chg_key, blk_done, busy, error}
    localparam logic [10:0] E_ERR = 11'h001, E_BUSY = 11'h002, E_BD  = 11'h004, E_DCK = 11'h008;
    localparam logic [10:0] E_OSE = 11'h010, E_OV   = 11'h020, E_CS  = 11'h040, E_LK  = 11'h080;
    localparam logic [10:0] E_BSE = 11'h100, E_KSE  = 11'h200, E_OPT = 11'h400;

    // Model phases
    localparam int P_IDLE = 0, P_KEYIN = 1, P_KEYWAIT = 2, P_BLKIN = 3;
    localparam int P_KICK = 4, P_COREWAIT = 5, P_OUT = 6, P_ERR = 7;

    typedef struct packed {
        logic [7:0]  iv;
        logic [10:0] exp;
    } vec_t;

    logic clk;
    logic n_rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    aes_seq_ctrl_if bus ();

    aes_seq_ctrl #(
        .BEATS_PER_BLK (BPB),
        .KEY_BEATS     (KB),
        .TIMEOUT_CYC   (TO)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [10:0] dut_vec;
    assign dut_vec = {bus.opt_mode, bus.key_shift_en, bus.blk_shift_en, bus.load_key,
                      bus.core_start, bus.out_valid, bus.out_shift_en, bus.done_chg_key,
                      bus.blk_done, bus.busy, bus.error};

    // Reference model: job phase plus beats still owed in that phase.
    int          m_phase, m_left, m_wait;
    bit          m_mode, m_first;
    int          n_phase, n_left, n_wait;
    bit          n_mode, n_first;
    logic [10:0] m_exp;
    logic [10:0] last_dut;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_left  = 0;
        m_wait  = 0;
        m_mode  = 1'b0;
        m_first = 1'b0;
    endtask

    task automatic model_eval(input logic [7:0] iv);
        bit st, dt, ed, dv, rdy, kd, cd, clr;
        bit bad, tmo, waiting;
        bit kse, bse, lk, cs, ov, ose, dck, bd;
        {st, dt, ed, dv, rdy, kd, cd, clr} = iv;
        {kse, bse, lk, cs, ov, ose, dck, bd} = 8'h00;
        bad     = st && (m_phase != P_IDLE) && (m_phase != P_ERR);
        waiting = (m_phase == P_KEYWAIT) || (m_phase == P_COREWAIT);
`ifdef AES_CTRL_TIMEOUT_EN
        tmo = waiting && (m_wait + 1 >= TO);
`else
        tmo = 1'b0;
`endif
        n_phase = m_phase;
        n_left  = m_left;
        n_mode  = m_mode;
        n_first = 1'b0;
        case (m_phase)
            P_IDLE: if (st) begin
                n_mode  = ed;
                n_phase = dt ? P_KEYIN : P_BLKIN;
                n_left  = dt ? KB : BPB;
            end
            P_KEYIN: if (dv && !bad) begin
                kse    = 1'b1;
                n_left = m_left - 1;
                if (n_left == 0) begin
                    n_phase = P_KEYWAIT;
                    n_first = 1'b1;
                end
            end
            P_KEYWAIT: begin
                lk = m_first && !bad;
                if (kd && !bad) begin
                    dck     = 1'b1;
                    n_phase = P_IDLE;
                end else if (tmo) begin
                    n_phase = P_ERR;
                end
            end
            P_BLKIN: if (dv && !bad) begin
                bse    = 1'b1;
                n_left = m_left - 1;
                if (n_left == 0) n_phase = P_KICK;
            end
            P_KICK: begin
                cs      = !bad;
                n_phase = P_COREWAIT;
            end
            P_COREWAIT: begin
                if (cd) begin
                    n_phase = P_OUT;
                    n_left  = BPB;
                end else if (tmo) begin
                    n_phase = P_ERR;
                end
            end
            P_OUT: begin
                ov = 1'b1;
                if (rdy && !bad) begin
                    ose    = 1'b1;
                    n_left = m_left - 1;
                    if (n_left == 0) begin
                        bd      = 1'b1;
                        n_phase = P_IDLE;
                    end
                end
            end
            default: if (clr) n_phase = P_IDLE;
        endcase
        if (bad) n_phase = P_ERR;
        if (n_phase != m_phase || !waiting) n_wait = 0;
        else n_wait = m_wait + 1;
        m_exp = {m_mode && (m_phase != P_ERR), kse, bse, lk, cs, ov, ose, dck, bd,
                 m_phase != P_IDLE, m_phase == P_ERR};
    endtask

    // One clock cycle: drive at negedge, compare against the model, advance at posedge.
    task automatic step(input logic [7:0] iv);
        {bus.start, bus.data_type, bus.enc_dec, bus.data_valid, bus.out_ready, bus.key_done,
         bus.core_done, bus.clear_err} = iv;
        #2;
        model_eval(iv);
        last_dut = dut_vec;
        check("model_outputs", 32'(dut_vec), 32'(m_exp));
        @(posedge clk);
        m_phase = n_phase;
        m_left  = n_left;
        m_wait  = n_wait;
        m_mode  = n_mode;
        m_first = n_first;
        @(negedge clk);
    endtask

    task automatic do_reset();
        {bus.start, bus.data_type, bus.enc_dec, bus.data_valid, bus.out_ready, bus.key_done,
         bus.core_done, bus.clear_err} = 8'h00;
        n_rst = 1'b0;
        model_reset();
        #2;
        check("reset_outputs", 32'(dut_vec), 32'h0);
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    vec_t tbl[18];
    int   kcnt, lkcnt;

    initial begin
        n_rst = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Encrypt block with input gaps and output backpressure 1,0,0,1,1,0,1.
        tbl[0]  = '{I_ST,       11'h000};
        tbl[1]  = '{I_DV,       E_BSE | E_BUSY};
        tbl[2]  = '{8'h00,      E_BUSY};
        tbl[3]  = '{I_DV,       E_BSE | E_BUSY};
        tbl[4]  = '{I_DV,       E_BSE | E_BUSY};
        tbl[5]  = '{8'h00,      E_BUSY};
        tbl[6]  = '{I_DV,       E_BSE | E_BUSY};
        tbl[7]  = '{8'h00,      E_CS | E_BUSY};
        tbl[8]  = '{8'h00,      E_BUSY};
        tbl[9]  = '{I_CD,       E_BUSY};
        tbl[10] = '{I_RDY,      E_OV | E_OSE | E_BUSY};
        tbl[11] = '{8'h00,      E_OV | E_BUSY};
        tbl[12] = '{8'h00,      E_OV | E_BUSY};
        tbl[13] = '{I_RDY,      E_OV | E_OSE | E_BUSY};
        tbl[14] = '{I_RDY,      E_OV | E_OSE | E_BUSY};
        tbl[15] = '{8'h00,      E_OV | E_BUSY};
        tbl[16] = '{I_RDY,      E_OV | E_OSE | E_BD | E_BUSY};
        tbl[17] = '{8'h00,      11'h000};
        for (int i = 0; i < 18; i++) begin
            step(tbl[i].iv);
            check($sformatf("table[%0d]", i), 32'(last_dut), 32'(tbl[i].exp));
        end

        // Decrypt key load, 8 beats with one gap, key_done 5 cycles after load.
        kcnt  = 0;
        lkcnt = 0;
        step(I_ST | I_DT | I_ED);
        for (int i = 0; i < KB; i++) begin
            step(I_DV);
            kcnt += int'(last_dut[9]);
            if (i == 3) step(8'h00);
        end
        for (int i = 0; i < 5; i++) begin
            step(8'h00);
            lkcnt += int'(last_dut[7]);
        end
        check("key_opt_mode", 32'(last_dut[10]), 32'd1);
        step(I_KD);
        check("done_chg_key", 32'(last_dut[3]), 32'd1);
        check("key_shift_cnt", 32'(kcnt), 32'(KB));
        check("load_key_cnt", 32'(lkcnt), 32'd1);
        step(8'h00);
        check("key_idle_busy", 32'(last_dut[1]), 32'd0);

        // Illegal start during block fetch, then clear_err with a start that must be dropped.
        step(I_ST);
        step(I_DV);
        step(I_DV);
        step(I_ST | I_DV);
        check("err_shift_mask", 32'(last_dut[8]), 32'd0);
        step(I_DV);
        check("err_flag", 32'(last_dut[0]), 32'd1);
        check("err_no_shift", 32'(last_dut[8]), 32'd0);
        step(I_ST | I_CLR);
        step(I_DV);
        check("err_start_drop", 32'(last_dut[1]), 32'd0);

        // Reset mid-CORE_WAIT; a stale core_done must not revive the job.
        step(I_ST);
        for (int i = 0; i < BPB; i++) step(I_DV);
        step(8'h00);
        step(8'h00);
        step(8'h00);
        do_reset();
        step(I_CD);
        check("rst_busy", 32'(last_dut[1]), 32'd0);
        step(I_RDY);
        check("rst_out_valid", 32'(last_dut[5]), 32'd0);

        // Stall in CORE_WAIT with no core_done.
        step(I_ST);
        for (int i = 0; i < BPB; i++) step(I_DV);
        step(8'h00);
`ifdef AES_CTRL_TIMEOUT_EN
        for (int i = 0; i < TO; i++) step(8'h00);
        step(8'h00);
        check("timeout_error", 32'(last_dut[0]), 32'd1);
        step(I_CLR);
`else
        for (int i = 0; i < 1000; i++) step(8'h00);
        check("no_timeout_busy", 32'(last_dut[1:0]), 32'd2);
        step(I_CD);
        for (int i = 0; i < BPB; i++) step(I_RDY);
        check("drain_blk_done", 32'(last_dut[2]), 32'd1);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            logic [7:0] iv;
            iv[7] = ($urandom_range(0, 99) < 4);
            iv[6] = 1'($urandom);
            iv[5] = 1'($urandom);
            iv[4] = ($urandom_range(0, 99) < 60);
            iv[3] = ($urandom_range(0, 99) < 50);
            iv[2] = ($urandom_range(0, 99) < 12);
            iv[1] = ($urandom_range(0, 99) < 12);
            iv[0] = ($urandom_range(0, 99) < 25);
            step(iv);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
